// File: rtl/cpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_seq_ctrl
//  Purpose  : Multi-cycle control sequencer for the MIPS core. Each
//             instruction steps through FETCH, DECODE, EXEC, MEM and WB.
//             The sequencer handshakes with instruction and data memory and
//             gates the PC, IR and register-file write strobes. BREAK or a
//             memory timeout stops the core until reset.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   system clock, rising edge
//    rst          in   asynchronous reset, active-high
//    run          in   allow fetch of the next instruction
//    imem_ready   in   instruction memory data valid this cycle
//    dmem_ready   in   data memory access completes this cycle
//    dec_mem_cmd  in   memory command from the decoder
//    dec_reg_wen  in   register write request from the decoder
//    dec_break    in   decoder flags BREAK
//    imem_req     out  instruction fetch request
//    ir_wen       out  instruction register load strobe
//    pc_wen       out  PC update strobe
//    dmem_req     out  data memory request
//    dmem_cmd     out  command to data memory (MEM_NOP when idle)
//    rf_wen       out  register-file write enable
//    state        out  current state (FETCH=0 .. ERR=6)
//    halted       out  core stopped (HALT or ERR)
//    err          out  memory timeout occurred
//    inst_count   out  instructions retired, wraps
// ============================================================================
module cpu_seq_ctrl #(
  parameter int unsigned           MEM_TIMEOUT = 16,
  parameter int unsigned           W_CNT       = 32,
  parameter int unsigned           W_TMO       = 8,
  parameter int unsigned           W_MEM_CMD   = 2,
  parameter logic [W_MEM_CMD-1:0]  MEM_NOP     = '0,
  parameter logic [W_MEM_CMD-1:0]  MEM_READ    = W_MEM_CMD'(1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic [W_MEM_CMD-1:0] dec_mem_cmd,
  input  logic                 dec_reg_wen,
  input  logic                 dec_break,
  output logic                 imem_req,
  output logic                 ir_wen,
  output logic                 pc_wen,
  output logic                 dmem_req,
  output logic [W_MEM_CMD-1:0] dmem_cmd,
  output logic                 rf_wen,
  output logic [2:0]           state,
  output logic                 halted,
  output logic                 err,
  output logic [W_CNT-1:0]     inst_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [W_TMO-1:0] TMO_LIMIT  = W_TMO'(MEM_TIMEOUT);
  localparam bit               TMO_ENABLE = (MEM_TIMEOUT != 0);

  state_t                 state_q;
  state_t                 state_n;
  logic [W_TMO-1:0]       wait_cnt;
  logic [W_TMO-1:0]       wait_cnt_inc;
  logic [W_MEM_CMD-1:0]   cmd_q;
  logic                   waiting;
  logic                   timeout;

  assign wait_cnt_inc = wait_cnt + W_TMO'(1);

  // --------------------------------------------------------------------------
  // Next state and Mealy strobes. Requests depend only on state (and run in
  // FETCH) so they stay high for every cycle of a wait; the strobes also
  // depend on the ready inputs.
  // --------------------------------------------------------------------------
  always_comb begin
    state_n  = state_q;
    imem_req = 1'b0;
    ir_wen   = 1'b0;
    pc_wen   = 1'b0;
    dmem_req = 1'b0;
    dmem_cmd = MEM_NOP;
    rf_wen   = 1'b0;
    halted   = 1'b0;
    err      = 1'b0;
    waiting  = 1'b0;
    timeout  = 1'b0;

    case (state_q)
      S_FETCH: begin
        // With run low the fetch is not requested at all; a pending request
        // is abandoned and restarts cleanly when run returns.
        if (run) begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_wen  = 1'b1;
            state_n = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        state_n = dec_break ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (dec_mem_cmd != MEM_NOP) begin
          state_n = S_MEM;
        end else if (dec_reg_wen) begin
          state_n = S_WB;
        end else begin
          pc_wen  = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_MEM: begin
        // The command latched in EXEC drives the port, so it cannot move
        // while the access is waiting even if the decoder input changes.
        dmem_req = 1'b1;
        dmem_cmd = cmd_q;
        if (dmem_ready) begin
          if (cmd_q == MEM_READ) begin
            state_n = S_WB;
          end else begin
            pc_wen  = 1'b1;
            state_n = S_FETCH;
          end
        end
      end
      S_WB: begin
        rf_wen  = 1'b1;
        pc_wen  = 1'b1;
        state_n = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_ERR: begin
        halted = 1'b1;
        err    = 1'b1;
      end
      default: begin
        state_n = S_ERR;
      end
    endcase

    // A ready in the limit cycle clears 'waiting', so the normal transition
    // wins over the timeout.
    waiting = (imem_req & ~imem_ready) | (dmem_req & ~dmem_ready);
    timeout = TMO_ENABLE && waiting && (wait_cnt_inc == TMO_LIMIT);
    if (timeout) begin
      state_n = S_ERR;
    end

    // Outputs fall as soon as reset asserts, without waiting for an edge.
    if (rst) begin
      imem_req = 1'b0;
      ir_wen   = 1'b0;
      pc_wen   = 1'b0;
      dmem_req = 1'b0;
      dmem_cmd = MEM_NOP;
      rf_wen   = 1'b0;
      halted   = 1'b0;
      err      = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State, wait counter, latched memory command and retired counter.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt   <= '0;
      cmd_q      <= MEM_NOP;
      inst_count <= '0;
    end else begin
      state_q <= state_n;

      // Any state change or any cycle without an outstanding wait (e.g. run
      // dropped during fetch) restarts the count.
      if ((state_n != state_q) || !waiting) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt_inc;
      end

      if (state_q == S_EXEC) begin
        cmd_q <= dec_mem_cmd;
      end

      if (pc_wen) begin
        inst_count <= inst_count + W_CNT'(1);
      end
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_seq_ctrl
//  Purpose  : Self-checking bench for cpu_seq_ctrl. Directed sequences for
//             reset, ALU, BREAK, timeout and reset-during-access, plus a
//             randomized instruction stream checked through a scoreboard of
//             per-instruction expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_seq_ctrl;

  localparam int W_CNT  = 6;
  localparam int TMO    = 4;
  localparam int N_RAND = 150;
  localparam logic [1:0] NOP  = 2'd0;
  localparam logic [1:0] READ = 2'd1;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       imem_ready;
  logic       dmem_ready;
  logic [1:0] dec_mem_cmd;
  logic       dec_reg_wen;
  logic       dec_break;
  logic       imem_req;
  logic       ir_wen;
  logic       pc_wen;
  logic       dmem_req;
  logic [1:0] dmem_cmd;
  logic       rf_wen;
  logic [2:0] state;
  logic       halted;
  logic       err;
  logic [W_CNT-1:0] inst_count;

  cpu_seq_ctrl #(
    .MEM_TIMEOUT (TMO),
    .W_CNT       (W_CNT),
    .W_TMO       (4),
    .W_MEM_CMD   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .dec_mem_cmd (dec_mem_cmd),
    .dec_reg_wen (dec_reg_wen),
    .dec_break   (dec_break),
    .imem_req    (imem_req),
    .ir_wen      (ir_wen),
    .pc_wen      (pc_wen),
    .dmem_req    (dmem_req),
    .dmem_cmd    (dmem_cmd),
    .rf_wen      (rf_wen),
    .state       (state),
    .halted      (halted),
    .err         (err),
    .inst_count  (inst_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected behaviour of one retired instruction, derived from its class.
  typedef struct {
    int         lat;   // cycles from the ir_wen cycle to the pc_wen cycle
    bit         rf;    // rf_wen in the retire cycle
    int         dcyc;  // cycles with dmem_req high
    logic [1:0] cmd;
    int         cnt;   // inst_count after retire
  } exp_t;

  exp_t sbq[$];

  function automatic exp_t expect_for(logic [1:0] cmd, bit rw, int dd, int cnt);
    exp_t e;
    e.cmd = cmd;
    e.cnt = cnt;
    if (cmd == NOP) begin
      e.dcyc = 0;
      e.rf   = rw;
      e.lat  = rw ? 3 : 2;            // DECODE, EXEC(, WB)
    end else begin
      e.dcyc = dd + 1;
      e.rf   = (cmd == READ);
      e.lat  = (cmd == READ) ? 4 + dd : 3 + dd;
    end
    return e;
  endfunction

  // --------------------------------------------------------------------------
  // Monitor: pops one expectation per retire (pc_wen).
  // --------------------------------------------------------------------------
  bit         mon_en = 1'b0;
  bit         m_in_inst = 1'b0;
  bit         m_cnt_pend = 1'b0;
  int         m_cyc = 0;
  int         m_dcyc = 0;
  int         m_cnt_exp = 0;
  logic [1:0] m_cmd0 = 2'd0;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (m_cnt_pend) begin
        chk("inst_count_after_retire", inst_count, m_cnt_exp);
        m_cnt_pend = 1'b0;
      end
      if (ir_wen) begin
        m_in_inst = 1'b1;
        m_cyc     = 0;
        m_dcyc    = 0;
      end else if (m_in_inst) begin
        m_cyc++;
      end
      if (dmem_req) begin
        m_dcyc++;
        if (m_dcyc == 1) m_cmd0 = dmem_cmd;
        else chk("dmem_cmd_stable", dmem_cmd, m_cmd0);
      end
      if (!pc_wen) begin
        chk("rf_wen_outside_wb", rf_wen, 0);
      end else begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL retire_unexpected: got retire with empty scoreboard, expected none");
        end else begin
          e = sbq.pop_front();
          chk("retire_latency", m_cyc, e.lat);
          chk("retire_rf_wen", rf_wen, e.rf);
          chk("dmem_req_cycles", m_dcyc, e.dcyc);
          if (e.dcyc > 0) chk("dmem_cmd_value", m_cmd0, e.cmd);
          m_cnt_exp  = e.cnt;
          m_cnt_pend = 1'b1;
        end
        m_in_inst = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Random instruction stream with randomized fetch/data wait states.
  // --------------------------------------------------------------------------
  int cnt_model = 0;

  task automatic run_random(input int n);
    int  issued = 0, retired = 0, cyc = 0;
    int  di, dd = 0, iw = 0, dw = 0;
    bit  need_new = 1'b1;
    bit  c_ir, c_ird, c_dr, c_drd, c_ret;
    di = $urandom_range(0, 3);
    while (retired < n) begin
      @(posedge clk);
      #1;
      if (cyc++ > 6000) begin
        checks++;
        errors++;
        $display("FAIL random_stream_timeout: got %0d retired expected %0d", retired, n);
        return;
      end
      if (need_new) begin
        dec_mem_cmd = 2'($urandom_range(0, 3));
        dec_reg_wen = 1'($urandom_range(0, 1));
        dec_break   = 1'b0;
        dd          = $urandom_range(0, 3);
        cnt_model   = (cnt_model + 1) % (1 << W_CNT);
        sbq.push_back(expect_for(dec_mem_cmd, dec_reg_wen, dd, cnt_model));
        issued++;
        need_new = 1'b0;
      end
      run = ($urandom_range(0, 4) != 0);
      #1;
      imem_ready = imem_req && (iw >= di);
      dmem_ready = dmem_req && (dw >= dd);
      #1;
      c_ir = imem_req; c_ird = imem_ready;
      c_dr = dmem_req; c_drd = dmem_ready;
      c_ret = pc_wen;
      if (c_ir && !c_ird) iw++;
      else begin
        iw = 0;
        if (c_ird) di = $urandom_range(0, 3);
      end
      if (c_dr && !c_drd) dw++;
      else dw = 0;
      if (c_ret) begin
        retired++;
        need_new = 1'b1;
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int pcw, reqs;
    bit found;
    logic [2:0] exp_states [5];
    exp_states = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};

    rst = 1'b1; run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
    dec_mem_cmd = NOP; dec_reg_wen = 1'b1; dec_break = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_imem_req", imem_req, 0);
    chk("reset_ir_wen", ir_wen, 0);
    chk("reset_dmem_cmd", dmem_cmd, NOP);
    chk("reset_halted", halted, 0);
    chk("reset_count", inst_count, 0);

    // ADD: zero-wait memories, state sequence 0,1,2,4,0.
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("add_state_seq", state, exp_states[c]);
      if (c == 0) chk("add_ir_wen", ir_wen, 1);
      if (c == 3) begin
        chk("add_rf_wen", rf_wen, 1);
        chk("add_pc_wen", pc_wen, 1);
        run = 1'b0;
      end else if (c < 3) begin
        chk("add_pc_wen_idle", pc_wen, 0);
      end
    end
    chk("add_count", inst_count, 1);
    chk("paused_imem_req", imem_req, 0);
    cnt_model = 1;

    mon_en = 1'b1;
    run_random(N_RAND);

    // BREAK: halts without retiring, run has no further effect.
    @(posedge clk); #1;
    dec_break = 1'b1; dec_mem_cmd = NOP; dec_reg_wen = 1'b0;
    run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0;
    pcw = 0; found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      pcw += int'(pc_wen);
      if (state == 3'd5) begin found = 1'b1; break; end
    end
    mon_en = 1'b0;
    chk("break_reached", found, 1);
    chk("break_pc_wen", pcw, 0);
    chk("break_halted", halted, 1);
    chk("break_err", err, 0);
    chk("break_count", inst_count, cnt_model);
    chk("scoreboard_drained", sbq.size(), 0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1 run = c[0];
      @(negedge clk);
      chk("halt_sticky_state", state, 5);
      chk("halt_imem_req", imem_req, 0);
    end

    // Timeout: imem_ready held low.
    @(posedge clk); #1 rst = 1'b1; dec_break = 1'b0; imem_ready = 1'b0;
    #1;
    chk("reset_from_halt_state", state, 0);
    chk("reset_from_halt_halted", halted, 0);
    @(posedge clk); #1 rst = 1'b0;
    reqs = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (state == 3'd6) break;
      reqs += int'(imem_req);
    end
    chk("timeout_req_cycles", reqs, TMO);
    chk("timeout_state", state, 6);
    chk("timeout_err", err, 1);
    chk("timeout_imem_req", imem_req, 0);
    @(negedge clk);
    chk("timeout_err_sticky", err, 1);

    // Reset during a stalled store, after one store has retired.
    @(posedge clk); #1 rst = 1'b1;
    dec_mem_cmd = 2'd2; dec_reg_wen = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (inst_count == 1) begin found = 1'b1; break; end
    end
    chk("store_retired", found, 1);
    dmem_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dmem_req) begin found = 1'b1; break; end
    end
    chk("store_mem_reached", found, 1);
    chk("store_dmem_cmd", dmem_cmd, 2);
    rst = 1'b1;
    #1;
    chk("async_rst_dmem_req", dmem_req, 0);
    chk("async_rst_dmem_cmd", dmem_cmd, NOP);
    chk("async_rst_state", state, 0);
    chk("async_rst_count", inst_count, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("restart_imem_req", imem_req, 1);
    chk("restart_state", state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Multi-cycle control sequencer for the MIPS core.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Handshakes with instruction and data memory, and gates the PC, IR and register-file write enables from the decoder's control outputs.
- Sits between the decoder, PC/IR registers, register file and memory ports. Stops the core on BREAK or on a memory timeout.

Parameters:
- MEM_TIMEOUT, default 16: maximum cycles spent waiting for a memory ready. 0 disables the timeout.
- W_CNT, default 32: width of the retired-instruction counter.
- W_TMO, default 8: width of the wait counter. MEM_TIMEOUT must be < 2^W_TMO.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- run  in  1  allow fetch of the next instruction
- imem_ready  in  1  instruction memory has data valid this cycle
- dmem_ready  in  1  data memory access completes this cycle
- dec_mem_cmd  in  W_MEM_CMD  mem_cmd from the decoder
- dec_reg_wen  in  1  reg_wen from the decoder (WREN/WDIS)
- dec_break  in  1  decoder flags OP_ZERO/F_BREAK
- imem_req  out  1  instruction fetch request
- ir_wen  out  1  instruction register load strobe
- pc_wen  out  1  PC update strobe; PC takes the pc_src-selected value
- dmem_req  out  1  data memory request
- dmem_cmd  out  W_MEM_CMD  command to data memory; MEM_NOP when idle
- rf_wen  out  1  register-file write enable
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6
- halted  out  1  core stopped (HALT or ERR)
- err  out  1  memory timeout occurred
- inst_count  out  W_CNT  instructions retired

Behaviour:
- Reset (rst=1, asynchronous):
  - state=FETCH, inst_count=0, wait counter=0.
  - All strobes and requests 0, dmem_cmd=MEM_NOP, halted=0, err=0.
  - Reset mid-access abandons the access. Outputs drop in the same cycle, without waiting for a clock edge.
- Output decoding:
  - Strobes are Mealy: state plus ready inputs.
  - imem_req and dmem_req are Moore-like: they stay high for every cycle of the wait.
- FETCH:
  - run=0: imem_req=0, remain in FETCH. Pausing happens only at instruction boundaries.
  - run=1: imem_req=1. When imem_ready=1, ir_wen=1 for that cycle and the next state is DECODE; otherwise remain in FETCH.
  - run falling while a request is outstanding: imem_req drops and the fetch restarts when run returns.
- DECODE (1 cycle, all strobes 0):
  - dec_break=1: go to HALT. PC is not advanced and the instruction is not counted.
  - Otherwise go to EXEC.
- EXEC (1 cycle):
  - dec_mem_cmd != MEM_NOP: go to MEM.
  - Else dec_reg_wen=1: go to WB.
  - Else: pc_wen=1, inst_count+1, go to FETCH.
- MEM:
  - dmem_req=1 and dmem_cmd=dec_mem_cmd, held stable until dmem_ready=1.
  - On ready with a read (MEM_READ): go to WB.
  - On ready with any other command: pc_wen=1, inst_count+1, go to FETCH.
- WB (1 cycle): rf_wen=1, pc_wen=1, inst_count+1, go to FETCH.
- Register writes:
  - rf_wen is asserted only in WB. It is never high in any other state, regardless of dec_reg_wen.
- Latency:
  - ALU instruction with zero-wait memory: 4 cycles.
  - Load: 5 cycles.
  - Store or no-write instruction: 3 or 4 cycles.
- Wait counter:
  - Increments each cycle in which imem_req=1 with imem_ready=0, or dmem_req=1 with dmem_ready=0.
  - Clears on every state change.
  - If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT, go to ERR; the request drops next cycle.
  - A ready arriving in the same cycle the counter reaches MEM_TIMEOUT wins: the normal transition occurs.
- HALT: halted=1, all strobes 0, requests 0. Left only by reset; run is ignored.
- ERR: halted=1, err=1, otherwise identical to HALT.
- inst_count wraps modulo 2^W_CNT.
- Unused state encodings (7): go to ERR on the next clock.

Test Plan:
- ADD instruction, imem_ready and dmem_ready tied to 1, run=1:
  - state sequence 0,1,2,4,0.
  - ir_wen high in cycle 1, rf_wen and pc_wen high in cycle 4.
  - inst_count=1.
- Load with dec_mem_cmd=MEM_READ, dmem_ready delayed 3 cycles:
  - dmem_req high for exactly 4 cycles with dmem_cmd stable, then WB.
  - Total 8 cycles; inst_count=1.
- Store, dmem_ready immediate: sequence FETCH, DECODE, EXEC, MEM, FETCH; rf_wen never asserted.
- dec_break=1 in DECODE:
  - state=5, halted=1, pc_wen never pulsed, inst_count unchanged.
  - run toggled afterwards has no effect; only rst clears.
- MEM_TIMEOUT=4, imem_ready held 0: after 4 request cycles state=6, err=1, imem_req=0 thereafter.
- rst pulsed during MEM wait: dmem_req, dmem_cmd and state clear asynchronously before the next edge. After release, FETCH restarts with inst_count=0.
